skid_buffer: RTL and testbench

// - Fully registered valid/ready pipeline stage (2-entry skid buffer): cuts the

---
 rtl/skid_buffer.sv | 112 +++++++++++
 tb/tb_skid_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry registered valid/ready stage.
// Cuts both the data/valid path and the ready path.
module skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [1:0]            count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_n;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  ready_q;
    logic                  valid_q;
    logic [1:0]            count_q;

    logic                  xfer_in;
    logic                  xfer_out;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;

    assign xfer_in  = s_valid_i & ready_q;
    assign xfer_out = valid_q & m_ready_i;

    // Next state and storage-load selects from the two handshakes.
    always_comb begin
        state_n        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    load_main_in = 1'b1;
                    state_n      = BUSY;
                end
            end
            BUSY: begin
                if (xfer_in && xfer_out) begin
                    load_main_in = 1'b1;
                end else if (xfer_in) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end else if (xfer_out) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (xfer_out) begin
                    load_main_skid = 1'b1;
                    state_n        = BUSY;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    // State plus registered handshake/count outputs; ready stays low in reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_n;
            ready_q <= (state_n != FULL);
            valid_q <= (state_n != EMPTY);
            count_q <= state_n;
        end
    end

    // Payload storage: main is always the older word.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= s_data_i;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s_data_i;
            end
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = valid_q;
    assign m_data_o  = main_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: scoreboard bench for skid_buffer.
// Directed scenarios plus a long random handshake run.
module tb_skid_buffer;

    logic       clk_i;
    logic       rstn_i;
    logic [7:0] s_data_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [1:0] count_o;

    int         n_run;
    int         n_fail;
    int         n_out;
    logic [7:0] sb_q[$];
    logic       rdy_ok;
    logic       stall;
    logic [7:0] stall_data;

    skid_buffer #(.DATA_WIDTH(8)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .s_data_i (s_data_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .m_data_o (m_data_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .count_o  (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Ready may only be high once an edge has been seen out of reset.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rdy_ok <= 1'b0;
        else         rdy_ok <= 1'b1;
    end

    // Monitor: sample mid-cycle, compare against queue, then record transfers.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            sb_q.delete();
            stall = 1'b0;
        end else begin
            chk("count", 32'(count_o), 32'(sb_q.size()));
            chk("s_ready", 32'(s_ready_o), 32'(rdy_ok && sb_q.size() < 2));
            chk("m_valid", 32'(m_valid_o), 32'(sb_q.size() != 0));
            if (stall) chk("stall_data", 32'(m_data_o), 32'(stall_data));
            if (m_valid_o && m_ready_i) begin
                if (sb_q.size() == 0) chk("sb_empty", 32'(1), 32'(0));
                else chk("m_data", 32'(m_data_o), 32'(sb_q.pop_front()));
                n_out++;
            end
            if (s_valid_i && s_ready_o) sb_q.push_back(s_data_i);
            stall      = m_valid_o && !m_ready_i;
            stall_data = m_data_o;
        end
    end

    initial begin
        int  n0;
        logic acc;
        n_run     = 0;
        n_fail    = 0;
        n_out     = 0;
        stall     = 1'b0;
        rstn_i    = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = 8'h00;
        m_ready_i = 1'b0;

        // Reset state, before any clock edge.
        #2;
        chk("rst_valid", 32'(m_valid_o), 32'(0));
        chk("rst_ready", 32'(s_ready_o), 32'(0));
        chk("rst_count", 32'(count_o), 32'(0));
        chk("rst_data", 32'(m_data_o), 32'(0));
        #15;
        rstn_i = 1'b1;
        #1;
        chk("rel_ready0", 32'(s_ready_o), 32'(0));
        cyc();
        chk("rel_ready1", 32'(s_ready_o), 32'(1));
        chk("rel_valid", 32'(m_valid_o), 32'(0));
        chk("rel_count", 32'(count_o), 32'(0));

        // Full-rate stream.
        n0 = n_out;
        m_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = 8'(i);
            cyc();
            if (i == 1) begin
                chk("lat_valid", 32'(m_valid_o), 32'(1));
                chk("lat_data", 32'(m_data_o), 32'(1));
            end
        end
        s_valid_i = 1'b0;
        cyc();
        chk("stream_n", 32'(n_out - n0), 32'(16));
        chk("stream_empty", 32'(m_valid_o), 32'(0));

        // Fill with downstream stalled.
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 8'hA1;
        cyc();
        s_data_i  = 8'hA2;
        cyc();
        s_valid_i = 1'b0;
        chk("full_count", 32'(count_o), 32'(2));
        chk("full_ready", 32'(s_ready_o), 32'(0));
        chk("full_data", 32'(m_data_o), 32'(8'hA1));
        cyc();
        cyc();
        chk("hold_data", 32'(m_data_o), 32'(8'hA1));
        m_ready_i = 1'b1;
        cyc();
        chk("drain1", 32'(m_data_o), 32'(8'hA2));
        chk("drain_ready", 32'(s_ready_o), 32'(1));
        cyc();
        chk("drain_empty", 32'(count_o), 32'(0));

        // FULL with both handshakes high: only the output side moves.
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 8'hB1;
        cyc();
        s_data_i  = 8'hB2;
        cyc();
        s_data_i  = 8'hB3;
        m_ready_i = 1'b1;
        cyc();
        chk("fb_count", 32'(count_o), 32'(1));
        chk("fb_data", 32'(m_data_o), 32'(8'hB2));
        chk("fb_ready", 32'(s_ready_o), 32'(1));
        cyc();
        chk("fb_accept", 32'(m_data_o), 32'(8'hB3));
        s_valid_i = 1'b0;
        cyc();
        cyc();

        // Reset mid-cycle while FULL.
        m_ready_i = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 8'hC1;
        cyc();
        s_data_i  = 8'hC2;
        cyc();
        s_valid_i = 1'b0;
        chk("mr_full", 32'(count_o), 32'(2));
        #2;
        rstn_i = 1'b0;
        #1;
        chk("mr_valid", 32'(m_valid_o), 32'(0));
        chk("mr_ready", 32'(s_ready_o), 32'(0));
        chk("mr_count", 32'(count_o), 32'(0));
        chk("mr_data", 32'(m_data_o), 32'(0));
        m_ready_i = 1'b1;
        cyc();
        cyc();
        #1;
        rstn_i = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        chk("mr_gone", 32'(m_valid_o), 32'(0));

        // Random handshakes; upstream holds a refused word.
        for (int i = 0; i < 10000; i++) begin
            acc = s_valid_i && s_ready_o;
            if (!s_valid_i || acc) begin
                s_valid_i = 1'($urandom);
                s_data_i  = 8'($urandom);
            end
            m_ready_i = 1'($urandom);
            cyc();
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("rand_drain", 32'(sb_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
